// File: rtl/tcm_pkg.sv
// Shared types for the tightly-coupled memory.
// Controller states and response-stage flags.
package tcm_pkg;

  typedef enum logic [1:0] {
    TCM_RESET,
    TCM_FILL,
    TCM_READY
  } tcm_state_e;

  localparam int TCM_MAX_LATENCY = 4;

  // Control bits carried by each response stage.
  // Read data travels alongside in a width-matched array.
  typedef struct packed {
    logic valid;
    logic err;
    logic wr;
  } tcm_rsp_t;

endpackage

// File: rtl/tcm_ram_array.sv
// Behavioural byte-masked single-port RAM.
// Synchronous read; a read always sees the previous cycle's write.
module tcm_ram_array #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 4096,
  parameter int    AW         = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-masked write, or registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
          if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/tcm_mem_top.sv
// Parametrised single-port TCM behind a req/gnt/rvalid bus.
// FSM, zero-fill, range check and fixed-latency response pipeline.
module tcm_mem_top
  import tcm_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 4096,
  parameter int    ADDR_WIDTH   = 12,
  parameter int    READ_LATENCY = 1,
  parameter int    ZERO_INIT    = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int LT = READ_LATENCY;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (LT < 1 || LT > TCM_MAX_LATENCY) begin : g_bad_lat
    $error("READ_LATENCY out of range");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH exceeds address space");
  end

  tcm_state_e state_q, state_d;
  logic [AW-1:0] fill_q;
  logic fill, accept, in_range;
  logic ram_en, ram_we;
  logic [BW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, rd_data;
  tcm_rsp_t rsp_q [LT];

  // Controller state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= TCM_RESET;
    else         state_q <= state_d;
  end

  // Next state, grant and fill strobe.
  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      TCM_RESET: state_d = (ZERO_INIT != 0) ? TCM_FILL : TCM_READY;
      TCM_FILL: begin
        fill = 1'b1;
        if (fill_q == AW'(DEPTH - 1)) state_d = TCM_READY;
      end
      TCM_READY: gnt_o = 1'b1;
      default:   state_d = TCM_RESET;
    endcase
  end

  // Fill address; held at 0 outside FILL so an aborted fill restarts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q != TCM_FILL) fill_q <= '0;
    else                                fill_q <= fill_q + 1'b1;
  end

  assign accept   = req_i & gnt_o;
  assign in_range = {1'b0, addr_i} < (ADDR_WIDTH+1)'(DEPTH);

  assign ram_en    = fill | (accept & in_range);
  assign ram_we    = fill | we_i;
  assign ram_be    = fill ? '1 : be_i;
  assign ram_addr  = fill ? fill_q : addr_i[AW-1:0];
  assign ram_wdata = fill ? '0 : wdata_i;

  tcm_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Response control pipeline; reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LT; i++) rsp_q[i] <= '0;
    end else begin
      rsp_q[0] <= '{valid: accept,
                    err:   accept & ~in_range,
                    wr:    accept & we_i};
      for (int i = 1; i < LT; i++) rsp_q[i] <= rsp_q[i-1];
    end
  end

  // RAM output is only data for a successful read.
  assign rd_data = (rsp_q[0].valid & ~rsp_q[0].err & ~rsp_q[0].wr)
                 ? ram_rdata : '0;

  assign rvalid_o = rsp_q[LT-1].valid;
  assign err_o    = rsp_q[LT-1].valid & rsp_q[LT-1].err;

  if (LT == 1) begin : g_lat1
    assign rdata_o = rd_data;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] dat_q [1:LT-1];

    // Delay read data to line up with the control bits.
    always_ff @(posedge clk_i) begin
      dat_q[1] <= rd_data;
      for (int i = 2; i < LT; i++) dat_q[i] <= dat_q[i-1];
    end

    assign rdata_o = rsp_q[LT-1].valid ? dat_q[LT-1] : '0;
  end

endmodule

// File: tb/tb_tcm_mem_top.sv
// Directed bench for tcm_mem_top.
// Three instances cover latency 1/3, zero-fill and range errors.
module tb_tcm_mem_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // A: DEPTH 3000, latency 1, no fill
  logic        a_rst_n, a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [3:0]  a_be;
  logic [11:0] a_addr;
  logic [31:0] a_wdata, a_rdata;

  // B: DEPTH 16, 5-bit address, latency 3, no fill
  logic        b_rst_n, b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [4:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  // C: DEPTH 16, latency 1, zero fill
  logic        c_rst_n, c_req, c_gnt, c_we, c_rvalid, c_err;
  logic [3:0]  c_be;
  logic [3:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;

  tcm_mem_top #(
    .DATA_WIDTH(32), .DEPTH(3000), .ADDR_WIDTH(12),
    .READ_LATENCY(1), .ZERO_INIT(0), .INIT_FILE("")
  ) u_a (
    .clk_i(clk), .rst_ni(a_rst_n), .req_i(a_req), .gnt_o(a_gnt),
    .we_i(a_we), .be_i(a_be), .addr_i(a_addr), .wdata_i(a_wdata),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
  );

  tcm_mem_top #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5),
    .READ_LATENCY(3), .ZERO_INIT(0), .INIT_FILE("")
  ) u_b (
    .clk_i(clk), .rst_ni(b_rst_n), .req_i(b_req), .gnt_o(b_gnt),
    .we_i(b_we), .be_i(b_be), .addr_i(b_addr), .wdata_i(b_wdata),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
  );

  tcm_mem_top #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4),
    .READ_LATENCY(1), .ZERO_INIT(1), .INIT_FILE("")
  ) u_c (
    .clk_i(clk), .rst_ni(c_rst_n), .req_i(c_req), .gnt_o(c_gnt),
    .we_i(c_we), .be_i(c_be), .addr_i(c_addr), .wdata_i(c_wdata),
    .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dpat(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // One latency-1 access on A, response checked next negedge.
  task automatic a_txn(input logic we, input logic [3:0] be,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_d,
                       input string tag);
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    @(negedge clk);
    a_req = 1'b0;
    chk({tag, ".rvalid"}, 32'(a_rvalid), 32'd1);
    chk({tag, ".err"},    32'(a_err),    32'(exp_err));
    chk({tag, ".rdata"},  a_rdata,       exp_d);
  endtask

  // One latency-3 access on B.
  task automatic b_txn(input logic we, input logic [4:0] addr,
                       input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_d, input string tag);
    b_req = 1'b1; b_we = we; b_be = 4'hF; b_addr = addr; b_wdata = wd;
    @(negedge clk);
    b_req = 1'b0;
    chk({tag, ".early"}, 32'(b_rvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".rvalid"}, 32'(b_rvalid), 32'd1);
    chk({tag, ".err"},    32'(b_err),    32'(exp_err));
    chk({tag, ".rdata"},  b_rdata,       exp_d);
  endtask

  initial begin
    int  cnt;
    bit  done;
    int  j;
    logic        exp_v;
    logic [31:0] exp_d;

    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_be = '0;
    a_addr = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_be = '0;
    b_addr = '0; b_wdata = '0;
    c_rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0; c_be = '0;
    c_addr = '0; c_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst.a_gnt",    32'(a_gnt),    32'd0);
    chk("rst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst.a_rdata",  a_rdata,       32'd0);
    chk("rst.a_err",    32'(a_err),    32'd0);
    chk("rst.b_gnt",    32'(b_gnt),    32'd0);
    chk("rst.b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst.c_gnt",    32'(c_gnt),    32'd0);

    // T1: zero fill holds off grant for DEPTH cycles
    c_rst_n = 1'b1;
    cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (c_gnt) done = 1'b1;
      else       cnt++;
    end
    chk("t1.fill_cycles", 32'(cnt), 32'd16);
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'd5;
    @(negedge clk);
    c_req = 1'b0;
    chk("t1.rvalid", 32'(c_rvalid), 32'd1);
    chk("t1.rdata",  c_rdata,       32'd0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'd15;
    @(negedge clk);
    c_req = 1'b0;
    chk("t1.last_rdata", c_rdata, 32'd0);

    // A out of reset: grant one cycle after release
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("a.gnt", 32'(a_gnt), 32'd1);
    chk("a.idle_rvalid", 32'(a_rvalid), 32'd0);

    // T2: write then read back-to-back
    a_txn(1'b1, 4'hF, 12'd3, 32'hDEADBEEF, 1'b0, 32'd0, "t2.wr");
    a_txn(1'b0, 4'hF, 12'd3, 32'd0, 1'b0, 32'hDEADBEEF, "t2.rd");

    // T3: single byte lane merge; read with be=0
    a_txn(1'b1, 4'hF, 12'd7, 32'h11223344, 1'b0, 32'd0, "t3.wr");
    a_txn(1'b1, 4'b0100, 12'd7, 32'h00AA0000, 1'b0, 32'd0, "t3.pwr");
    a_txn(1'b0, 4'h0, 12'd7, 32'd0, 1'b0, 32'h11AA3344, "t3.rd");

    // No-op write still responds and leaves data alone
    a_txn(1'b1, 4'h0, 12'd3, 32'hFFFFFFFF, 1'b0, 32'd0, "be0.wr");
    a_txn(1'b0, 4'hF, 12'd3, 32'd0, 1'b0, 32'hDEADBEEF, "be0.rd");

    // T4: range boundary
    a_txn(1'b0, 4'hF, 12'd3000, 32'd0, 1'b1, 32'd0, "t4.rd_oob");
    a_txn(1'b1, 4'hF, 12'hFFF, 32'hFFFFFFFF, 1'b1, 32'd0, "t4.wr_oob");
    a_txn(1'b1, 4'hF, 12'd2999, 32'h0BADF00D, 1'b0, 32'd0, "t4.wr_last");
    a_txn(1'b0, 4'hF, 12'd2999, 32'd0, 1'b0, 32'h0BADF00D, "t4.rd_last");
    a_txn(1'b0, 4'hF, 12'd7, 32'd0, 1'b0, 32'h11AA3344, "t4.rd_keep");
    @(negedge clk);
    chk("a.idle.rvalid", 32'(a_rvalid), 32'd0);
    chk("a.idle.rdata",  a_rdata,       32'd0);
    chk("a.idle.err",    32'(a_err),    32'd0);

    // B out of reset
    b_rst_n = 1'b1;
    @(negedge clk);
    chk("b.gnt", 32'(b_gnt), 32'd1);

    // T5: 8 writes then 8 reads, all back-to-back, latency 3
    for (int n = 0; n < 19; n++) begin
      if (n < 16) begin
        b_req   = 1'b1;
        b_we    = (n < 8);
        b_be    = 4'hF;
        b_addr  = 5'(n % 8);
        b_wdata = dpat(n % 8);
      end else begin
        b_req = 1'b0;
      end
      @(negedge clk);
      j = n - 2;
      exp_v = (j >= 0 && j < 16);
      exp_d = (exp_v && j >= 8) ? dpat(j - 8) : 32'd0;
      chk($sformatf("t5.rvalid[%0d]", n), 32'(b_rvalid), 32'(exp_v));
      chk($sformatf("t5.rdata[%0d]", n),  b_rdata,       exp_d);
    end
    chk("t5.err", 32'(b_err), 32'd0);

    // T6: reset with two reads in flight
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd1;
    @(negedge clk);
    b_addr = 5'd2;
    @(negedge clk);
    b_req = 1'b0;
    b_rst_n = 1'b0;
    @(negedge clk);
    chk("t6.rst_rvalid0", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    chk("t6.rst_rvalid1", 32'(b_rvalid), 32'd0);
    b_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6.post_rvalid[%0d]", k), 32'(b_rvalid), 32'd0);
    end
    chk("t6.gnt", 32'(b_gnt), 32'd1);
    b_txn(1'b0, 5'd1, 32'd0, 1'b0, dpat(1), "t6.keep");

    // Out-of-range write must not alias onto addr 3
    b_txn(1'b1, 5'd19, 32'hFFFFFFFF, 1'b1, 32'd0, "b.wr_oob");
    b_txn(1'b0, 5'd3, 32'd0, 1'b0, dpat(3), "b.rd_alias");
    b_txn(1'b0, 5'd16, 32'd0, 1'b1, 32'd0, "b.rd_oob");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
